// File: rtl/tuple_hash_fifo.sv
// Fall-through tuple FIFO with two combinational XOR-fold hash indices on the head entry.
// Define TUPLE_HASH_COUNT_EN to expose the registered occupancy on port count.
module tuple_hash_fifo #(
   parameter int INPUT_WIDTH    = 96,
   parameter int OUTPUT_WIDTH   = 19,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INPUT_WIDTH-1:0]    din,
   input  logic                      wr_en,
   input  logic                      rd_en,
   output logic [INPUT_WIDTH-1:0]    dout,
   output logic                      full,
   output logic                      nearly_full,
   output logic                      empty,
`ifdef TUPLE_HASH_COUNT_EN
   output logic [MAX_DEPTH_BITS:0]   count,
`endif
   output logic [OUTPUT_WIDTH-1:0]   hash_0,
   output logic [OUTPUT_WIDTH-1:0]   hash_1
);

   localparam int DEPTH    = 2 ** MAX_DEPTH_BITS;
   localparam int DEPTH_M1 = DEPTH - 1;
   localparam int K        = (INPUT_WIDTH + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL = DEPTH[MAX_DEPTH_BITS:0];
   localparam logic [MAX_DEPTH_BITS:0]   CNT_NEAR = DEPTH_M1[MAX_DEPTH_BITS:0];
   localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = {{MAX_DEPTH_BITS{1'b0}}, 1'b1};
   localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = {{(MAX_DEPTH_BITS-1){1'b0}}, 1'b1};

   logic [INPUT_WIDTH-1:0]    mem_q [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [MAX_DEPTH_BITS:0]   count_q, count_d;
   logic                      wr_acc, rd_acc;

   // Flags come straight from the registered count so an async reset clears them at once.
   always_comb begin
      full        = (count_q == CNT_FULL);
      nearly_full = (count_q >= CNT_NEAR);
      empty       = (count_q == '0);
      wr_acc      = wr_en && !full;
      rd_acc      = rd_en && !empty;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left unreset; dout is masked while empty instead.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= din;
   end

   always_comb begin
      dout = '0;
      if (!empty) dout = mem_q[rd_ptr_q];
   end

   logic [K*OUTPUT_WIDTH-1:0]   padded;
   logic [OUTPUT_WIDTH-1:0]     slice;
   logic [2*OUTPUT_WIDTH-1:0]   dbl;

   // Rotate-left of slice i is taken as the upper half of {s,s} shifted left by i.
   always_comb begin
      padded                   = '0;
      padded[INPUT_WIDTH-1:0]  = dout;
      slice                    = '0;
      dbl                      = '0;
      hash_0                   = '0;
      hash_1                   = '0;
      for (int i = 0; i < K; i++) begin
         slice  = padded[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
         dbl    = {slice, slice} << (i % OUTPUT_WIDTH);
         hash_0 = hash_0 ^ slice;
         hash_1 = hash_1 ^ dbl[2*OUTPUT_WIDTH-1:OUTPUT_WIDTH];
      end
   end

`ifdef TUPLE_HASH_COUNT_EN
   assign count = count_q;
`else
   // Occupancy stays internal; it only drives the flags.
`endif

endmodule

// File: tb/tb_tuple_hash_fifo.sv
// Directed bench for tuple_hash_fifo: vector table plus hand sequences for reset, wrap and full/empty corners.
module tb_tuple_hash_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [95:0] din;
   logic        wr_en, rd_en;
   logic [95:0] dout;
   logic        full, nearly_full, empty;
   logic [18:0] hash_0, hash_1;
`ifdef TUPLE_HASH_COUNT_EN
   logic [3:0]  count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   tuple_hash_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .dout        (dout),
      .full        (full),
      .nearly_full (nearly_full),
      .empty       (empty),
`ifdef TUPLE_HASH_COUNT_EN
      .count       (count),
`endif
      .hash_0      (hash_0),
      .hash_1      (hash_1)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        wr;
      logic        rd;
      logic [95:0] din;
      logic        e;
      logic        f;
      logic        nf;
      logic [95:0] dout;
      logic [18:0] h0;
      logic [18:0] h1;
   } vec_t;

   vec_t vecs[$];

   // Bit j of the tuple lands in bit j%19 of hash_0 and, rotated by its slice index, in hash_1.
   function automatic void hmodel(input logic [95:0] d, output logic [18:0] h0, output logic [18:0] h1);
      h0 = '0;
      h1 = '0;
      for (int j = 0; j < 96; j++) begin
         if (d[j]) begin
            h0[j % 19]               = ~h0[j % 19];
            h1[((j % 19) + (j / 19)) % 19] = ~h1[((j % 19) + (j / 19)) % 19];
         end
      end
   endfunction

   task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check(input string name, input logic e, input logic f, input logic nf,
                        input logic [95:0] exp_dout);
      logic [18:0] m0, m1;
      hmodel(exp_dout, m0, m1);
      cmp({name, ".empty"}, {95'd0, empty}, {95'd0, e});
      cmp({name, ".full"}, {95'd0, full}, {95'd0, f});
      cmp({name, ".nearly_full"}, {95'd0, nearly_full}, {95'd0, nf});
      cmp({name, ".dout"}, dout, exp_dout);
      cmp({name, ".hash_0"}, {77'd0, hash_0}, {77'd0, m0});
      cmp({name, ".hash_1"}, {77'd0, hash_1}, {77'd0, m1});
   endtask

   task automatic cycle(input logic w, input logic r, input logic [95:0] d);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic add(input string n, input logic w, input logic r, input logic [95:0] d,
                      input logic e, input logic f, input logic nf, input logic [95:0] o,
                      input logic [18:0] h0, input logic [18:0] h1);
      vec_t v;
      v.name = n; v.wr = w; v.rd = r; v.din = d;
      v.e = e; v.f = f; v.nf = nf; v.dout = o; v.h0 = h0; v.h1 = h1;
      vecs.push_back(v);
   endtask

   initial begin
      logic [95:0] one;
      one = 96'd1;

      // Single entry round trip
      add("t2_wr",  1, 0, one,       0, 0, 0, one,       19'h1, 19'h1);
      add("t2_rd",  0, 1, '0,        1, 0, 0, '0,        19'h0, 19'h0);
      // Slice-position sensitivity of hash_1
      add("t3_wr0", 1, 0, one << 19, 0, 0, 0, one << 19, 19'h1, 19'h2);
      add("t3_wr1", 1, 0, one << 95, 0, 0, 0, one << 19, 19'h1, 19'h2);
      add("t3_rd0", 0, 1, '0,        0, 0, 0, one << 95, 19'h1, 19'h20);
      add("t3_rd1", 0, 1, '0,        1, 0, 0, '0,        19'h0, 19'h0);
      // Fill to full, overflow attempt, drain in order
      for (int k = 0; k < 8; k++)
         add($sformatf("t4_wr%0d", k), 1, 0, 96'h10 + 96'(k), 0, k == 7, k >= 6,
             96'h10, 19'h10, 19'h10);
      add("t4_ovf", 1, 0, 96'hFF, 0, 1, 1, 96'h10, 19'h10, 19'h10);
      for (int k = 1; k < 8; k++)
         add($sformatf("t4_rd%0d", k), 0, 1, '0, 0, 0, k == 1,
             96'h10 + 96'(k), 19'h10 + 19'(k), 19'h10 + 19'(k));
      add("t4_rd8", 0, 1, '0, 1, 0, 0, '0, 19'h0, 19'h0);

      wr_en = 1'b0; rd_en = 1'b0; din = '0;
      reset = 1'b1;
      #1;
      check("rst", 1, 0, 0, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Async reset with 3 entries: outputs clear without a clock edge
      for (int k = 0; k < 3; k++) cycle(1, 0, 96'hABC0 + 96'(k));
      check("t1_pre", 0, 0, 0, 96'hABC0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t1_rst", 1, 0, 0, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
         check(vecs[i].name, vecs[i].e, vecs[i].f, vecs[i].nf, vecs[i].dout);
         cmp({vecs[i].name, ".h0_hand"}, {77'd0, hash_0}, {77'd0, vecs[i].h0});
         cmp({vecs[i].name, ".h1_hand"}, {77'd0, hash_1}, {77'd0, vecs[i].h1});
      end

      // Steady occupancy of 4 with simultaneous read/write across pointer wrap
      for (int k = 0; k < 4; k++) cycle(1, 0, {32'hC0DE_0000, 64'h100 + 64'(k)});
      check("t5_fill", 0, 0, 0, {32'hC0DE_0000, 64'h100});
      for (int k = 0; k < 10; k++) begin
         cycle(1, 1, {32'hC0DE_0000, 64'h104 + 64'(k)});
         check($sformatf("t5_rw%0d", k), 0, 0, 0, {32'hC0DE_0000, 64'h101 + 64'(k)});
      end
      for (int k = 0; k < 3; k++) begin
         cycle(0, 1, '0);
         check($sformatf("t5_dr%0d", k), 0, 0, 0, {32'hC0DE_0000, 64'h10B + 64'(k)});
      end
      cycle(0, 1, '0);
      check("t5_end", 1, 0, 0, '0);

      // Read on empty is ignored
      cycle(0, 1, '0);
      check("t6_rd_empty", 1, 0, 0, '0);
      // Full with read+write: read taken, write dropped
      for (int k = 0; k < 8; k++) cycle(1, 0, 96'h5A5A_0000_0000_0000_0000_0200 + 96'(k));
      check("t6_full", 0, 1, 1, 96'h5A5A_0000_0000_0000_0000_0200);
      cycle(1, 1, 96'hDEAD);
      check("t6_rw_full", 0, 0, 1, 96'h5A5A_0000_0000_0000_0000_0201);
      for (int k = 2; k < 8; k++) begin
         cycle(0, 1, '0);
         check($sformatf("t6_pop%0d", k), 0, 0, 0, 96'h5A5A_0000_0000_0000_0000_0200 + 96'(k));
      end
      cycle(0, 1, '0);
      check("t6_last", 1, 0, 0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tuple_hash_fifo.md
Name: tuple_hash_fifo

Overview:
Small fall-through FIFO for flow tuples. Each entry is a 96-bit tuple {dst/src IP, dst/src port}. Two independent OUTPUT_WIDTH-bit hash indices are computed combinationally on the head entry, so a consumer sees the tuple and its hash indices together. It sits between the TCP header parser, which writes tuples, and the flow-table lookup, which pops tuples after using hash_0/hash_1 as SRAM indices.

Parameters:
INPUT_WIDTH, 96, tuple width in bits; also the FIFO word width.
OUTPUT_WIDTH, 19, width of each hash index.
MAX_DEPTH_BITS, 3, log2 of FIFO depth (DEPTH = 2**MAX_DEPTH_BITS = 8).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
din  in  INPUT_WIDTH  tuple to write.
wr_en  in  1  write strobe.
rd_en  in  1  pop the head entry.
dout  out  INPUT_WIDTH  head tuple (fall-through); all zeros when empty.
full  out  1  count == DEPTH.
nearly_full  out  1  count >= DEPTH-1.
empty  out  1  count == 0.
hash_0  out  OUTPUT_WIDTH  XOR-fold hash of dout.
hash_1  out  OUTPUT_WIDTH  rotated XOR-fold hash of dout.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- On reset: read/write pointers = 0, count = 0, empty = 1, full = 0, nearly_full = 0, dout = 0, hash_0 = hash_1 = 0.
- Storage array contents are not reset.
- Write is accepted when wr_en && !full. Stores din at the write pointer, which then increments modulo DEPTH.
- Read is accepted when rd_en && !empty. Read pointer increments modulo DEPTH.
- wr_en while full: ignored, no state change.
- rd_en while empty: ignored, no state change.
- Both accepted in the same cycle: count unchanged, both pointers advance.
- When full, a simultaneous rd_en+wr_en accepts the read only. The write is dropped because full is evaluated before the edge.
- Fall-through timing:
  - dout = mem[rd_ptr] combinationally whenever !empty.
  - A word written into an empty FIFO appears on dout, and empty deasserts, in the cycle after the write edge.
  - After a pop, the next entry appears immediately after the edge.
- Flags full, nearly_full and empty are derived from the registered count (0..DEPTH). There are no other flags.
- hash_0 and hash_1 are purely combinational from dout, with zero latency, and are valid whenever !empty.
- Hash definitions:
  - Split dout into slices s_i = dout[i*OUTPUT_WIDTH +: OUTPUT_WIDTH], for i = 0..K-1, where K = ceil(INPUT_WIDTH/OUTPUT_WIDTH).
  - The last slice is zero-padded at its MSBs. With the defaults, K = 6 and s_5 = {18'b0, dout[95]}.
  - hash_0 = XOR of all s_i.
  - hash_1 = XOR of rotl(s_i, i mod OUTPUT_WIDTH), where rotl is a left rotate within OUTPUT_WIDTH bits.
- Pointer wrap: after 8 writes and 8 reads in any interleaving, FIFO order is preserved across the wrap.

Optional Feature:
Macro TUPLE_HASH_COUNT_EN.
- Defined: adds output port count [MAX_DEPTH_BITS:0], the registered occupancy (0..DEPTH), reset to 0.
- Undefined: the port is absent. All other behaviour is identical.

Test Plan:
1. Reset mid-operation with 3 entries -> outputs are immediately, without waiting for a clock edge: empty = 1, dout = 0, hash_0 = 0, hash_1 = 0, full = 0.
2. Write din = 96'h1 into an empty FIFO -> next cycle: empty = 0, dout = 1, hash_0 = 19'h1, hash_1 = 19'h1. Pop -> empty = 1.
3. Write 96'h1<<19, then 96'h1<<95 -> head gives hash_0 = 1, hash_1 = 19'h2. After pop: hash_0 = 1, hash_1 = 19'h20.
4. Write 8 distinct tuples -> nearly_full = 1 after 7 writes, full = 1 after 8. A 9th wr_en is ignored. 8 pops return the tuples in write order, then empty = 1.
5. Fill 4 entries, then assert rd_en and wr_en together for 10 cycles -> occupancy stays 4, full/empty never toggle, and output order is preserved across pointer wrap.
6. rd_en on empty, and rd_en+wr_en while full -> empty case: no change. Full case: one entry popped, write dropped, count = 7.
